// File: rtl/controller_datapath_pkg.sv
// Shared definitions for the single-cycle stack/register machine:
// opcodes, data width and the control-field encodings.
package controller_datapath_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_BEQZ  = 4'h9;
  localparam logic [3:0] OP_LDI   = 4'hA;
  localparam logic [3:0] OP_PUSHI = 4'hB;
  localparam logic [3:0] OP_POP   = 4'hC;
  localparam logic [3:0] OP_PUSH  = 4'hD;
  localparam logic [3:0] OP_SADD  = 4'hE;

  typedef enum logic [1:0] {
    MEMIN_IMM = 2'b00,
    MEMIN_REG = 2'b01,
    MEMIN_SUM = 2'b10
  } memin_e;

  typedef enum logic [1:0] {
    SPI_HOLD = 2'b00,
    SPI_INC  = 2'b01,
    SPI_DEC  = 2'b10
  } spi_e;

endpackage

// File: rtl/controller_datapath_control.sv
// Combinational instruction decoder: maps the opcode to datapath control
// strobes. Stack bound checks are left to the datapath, which knows SP.
module cd_control
  import controller_datapath_pkg::*;
(
  input  logic [3:0] op,
  output logic       regw,
  output logic       memw,
  output logic [1:0] memin,
  output logic       sflag,
  output logic [1:0] spi,
  output logic       pcin,
  output logic       pci
);

  always_comb begin
    regw  = 1'b0;
    memw  = 1'b0;
    memin = MEMIN_IMM;
    sflag = 1'b0;
    spi   = SPI_HOLD;
    pcin  = 1'b0;
    pci   = 1'b1;
    case (op)
      OP_HALT: pci = 1'b0;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: regw = 1'b1;
      OP_JMP: begin
        pcin = 1'b1;
        pci  = 1'b0;
      end
      // BEQZ raises both: the datapath takes the target only when R[a]==0
      OP_BEQZ: pcin = 1'b1;
      OP_PUSHI: begin
        memw = 1'b1;
        spi  = SPI_INC;
      end
      OP_POP: begin
        regw  = 1'b1;
        sflag = 1'b1;
        spi   = SPI_DEC;
      end
      OP_PUSH: begin
        memw  = 1'b1;
        memin = MEMIN_REG;
        spi   = SPI_INC;
      end
      OP_SADD: begin
        memw  = 1'b1;
        memin = MEMIN_SUM;
        spi   = SPI_DEC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/controller_datapath.sv
// Single-cycle processor top: PC, register file, entry-counting stack and
// ALU, steered by the cd_control decoder.
module controller_datapath
  import controller_datapath_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int SDEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] isr,
  input  logic        stall,
  output logic [15:0] pcout,
  output logic [15:0] tos,
  output logic        halted,
  output logic        err
);

  localparam int SPW  = $clog2(SDEPTH + 1);
  localparam int IDXW = $clog2(SDEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);

  logic [3:0]        op, fa, fb, fc;
  logic [DATA_W-1:0] imm12, imm8;
  logic              regw, memw, sflag, pcin, pci;
  logic [1:0]        memin, spi;

  logic [DATA_W-1:0] regs  [NREG];
  logic [DATA_W-1:0] stack [SDEPTH];
  logic [SPW-1:0]    sp;
  logic [IDXW-1:0]   top_idx, sec_idx, wr_idx;
  logic [DATA_W-1:0] rega, regb, regc, top_val, sec_val;
  logic [DATA_W-1:0] reg_wdata, stk_wdata, pc_next;
  logic              sp_ok, run;

  assign op    = isr[15:12];
  assign fa    = isr[11:8];
  assign fb    = isr[7:4];
  assign fc    = isr[3:0];
  assign imm12 = {4'h0, isr[11:0]};
  assign imm8  = {8'h00, isr[7:0]};

  cd_control u_ctrl (
    .op    (op),
    .regw  (regw),
    .memw  (memw),
    .memin (memin),
    .sflag (sflag),
    .spi   (spi),
    .pcin  (pcin),
    .pci   (pci)
  );

  function automatic logic [DATA_W-1:0] alu(input logic [3:0] f,
                                            input logic [DATA_W-1:0] x,
                                            input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] r;
    case (f)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign run     = !halted && !stall;
  assign rega    = regs[fa];
  assign regb    = regs[fb];
  assign regc    = regs[fc];
  assign top_idx = IDXW'(sp - SP_ONE);
  assign sec_idx = IDXW'(sp - SP_TWO);
  assign top_val = stack[top_idx];
  assign sec_val = stack[sec_idx];
  // SADD folds its result into the lower of the two popped slots
  assign wr_idx  = (memin == MEMIN_SUM) ? sec_idx : IDXW'(sp);
  assign tos     = (sp == '0) ? '0 : top_val;

  always_comb begin
    sp_ok = 1'b1;
    if (op == OP_SADD)       sp_ok = (sp >= SP_TWO);
    else if (spi == SPI_INC) sp_ok = (sp != SP_FULL);
    else if (spi == SPI_DEC) sp_ok = (sp != '0);

    if (sflag)              reg_wdata = sp_ok ? top_val : '0;
    else if (op == OP_LDI)  reg_wdata = imm8;
    else                    reg_wdata = alu(op, regb, regc);

    case (memin)
      MEMIN_REG: stk_wdata = rega;
      MEMIN_SUM: stk_wdata = top_val + sec_val;
      default:   stk_wdata = imm12;
    endcase

    pc_next = pcout;
    if (pcin && (op == OP_JMP || rega == '0))
      pc_next = (op == OP_JMP) ? imm12 : imm8;
    else if (pci)
      pc_next = pcout + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcout  <= '0;
      sp     <= '0;
      halted <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < NREG; i++)   regs[i]  <= '0;
      for (int i = 0; i < SDEPTH; i++) stack[i] <= '0;
    end else if (run) begin
      pcout <= pc_next;
      if (op == OP_HALT)    halted <= 1'b1;
      if (!sp_ok)           err <= 1'b1;
      if (regw)             regs[fa] <= reg_wdata;
      if (memw && sp_ok)    stack[wr_idx] <= stk_wdata;
      if (sp_ok) begin
        case (spi)
          SPI_INC: sp <= sp + SP_ONE;
          SPI_DEC: sp <= sp - SP_ONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controller_datapath.sv
// Bench for controller_datapath: directed programs plus random programs
// checked cycle by cycle against an architectural model of the machine.
module tb_controller_datapath;

  logic        clk, reset, stall;
  logic [15:0] isr, pcout, tos;
  logic        halted, err;

  logic [15:0] imem [4096];
  int n_chk = 0;
  int n_fail = 0;

  // architectural model state
  logic [15:0] mr [16];
  logic [15:0] ms [$];
  logic [15:0] mpc;
  logic        mhalt, merr;

  controller_datapath dut (
    .clk(clk), .reset(reset), .isr(isr), .stall(stall),
    .pcout(pcout), .tos(tos), .halted(halted), .err(err)
  );

  always_comb isr = imem[pcout[11:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 16'h0;
    ms.delete();
    mpc = 16'h0; mhalt = 1'b0; merr = 1'b0;
  endtask

  task automatic model_exec();
    logic [15:0] ins, x, y;
    logic [3:0]  op, a, b, c;
    if (mhalt || stall) return;
    ins = imem[mpc[11:0]];
    op = ins[15:12]; a = ins[11:8]; b = ins[7:4]; c = ins[3:0];
    mpc = mpc + 16'd1;
    case (op)
      4'h0: begin mhalt = 1'b1; mpc = mpc - 16'd1; end
      4'h1: mr[a] = mr[b] + mr[c];
      4'h2: mr[a] = mr[b] - mr[c];
      4'h3: mr[a] = mr[b] & mr[c];
      4'h4: mr[a] = mr[b] | mr[c];
      4'h5: mr[a] = mr[b] ^ mr[c];
      4'h8: mpc = {4'h0, ins[11:0]};
      4'h9: if (mr[a] == 16'h0) mpc = {8'h0, ins[7:0]};
      4'hA: mr[a] = {8'h0, ins[7:0]};
      4'hB: if (ms.size() == 16) merr = 1'b1; else ms.push_back({4'h0, ins[11:0]});
      4'hC: if (ms.size() == 0) begin mr[a] = 16'h0; merr = 1'b1; end
            else mr[a] = ms.pop_back();
      4'hD: if (ms.size() == 16) merr = 1'b1; else ms.push_back(mr[a]);
      4'hE: if (ms.size() < 2) merr = 1'b1;
            else begin x = ms.pop_back(); y = ms.pop_back(); ms.push_back(x + y); end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_exec();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) imem[i] = 16'h7000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_mem();
    for (int i = 0; i < 16; i++) imem[i] = 16'($urandom());
    @(negedge clk);
    reset = 1'b1; stall = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (pcout !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pcout); end
    n_chk++; if (tos !== 16'h0) begin n_fail++; $display("FAIL reset_tos: got %h want 0000", tos); end
    n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_stack_program();
    logic [15:0] p [11] = '{16'hB00A, 16'hC900, 16'hB00A, 16'hCA00, 16'hB00A, 16'hCB00,
                            16'hB00A, 16'hCC00, 16'hB00A, 16'hD100, 16'h0FFF};
    clear_mem();
    for (int i = 0; i < 11; i++) imem[i] = p[i];
    apply_reset();
    repeat (11) tick();
    n_chk++; if (pcout !== 16'd10) begin n_fail++; $display("FAIL prog_pc: got %h want 000a", pcout); end
    n_chk++; if (tos !== 16'h0) begin n_fail++; $display("FAIL prog_tos: got %h want 0000", tos); end
    n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL prog_halted: got %b want 1", halted); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL prog_err: got %b want 0", err); end
    // same program, then push R9..R12 to expose the popped values
    imem[10] = 16'hD900; imem[11] = 16'hDA00; imem[12] = 16'hDB00; imem[13] = 16'hDC00;
    imem[14] = 16'h0000;
    apply_reset();
    repeat (10) tick();
    for (int r = 0; r < 4; r++) begin
      tick();
      n_chk++; if (tos !== 16'd10) begin n_fail++; $display("FAIL prog_reg%0d: got %h want 000a", 9 + r, tos); end
    end
  endtask

  task automatic test_alu();
    clear_mem();
    imem[0] = 16'hA105; imem[1] = 16'hA203; imem[2] = 16'h2312; imem[3] = 16'hD300;
    imem[4] = 16'h2321; imem[5] = 16'hD300; imem[6] = 16'h0000;
    apply_reset();
    repeat (4) tick();
    n_chk++; if (tos !== 16'h0002) begin n_fail++; $display("FAIL alu_sub: got %h want 0002", tos); end
    repeat (2) tick();
    n_chk++; if (tos !== 16'hFFFE) begin n_fail++; $display("FAIL alu_sub_wrap: got %h want fffe", tos); end
  endtask

  task automatic test_branch();
    clear_mem();
    imem[0] = 16'hA100; imem[1] = 16'h9105;
    apply_reset();
    repeat (2) tick();
    n_chk++; if (pcout !== 16'h0005) begin n_fail++; $display("FAIL beqz_taken: got %h want 0005", pcout); end
    imem[0] = 16'hA101;
    apply_reset();
    repeat (2) tick();
    n_chk++; if (pcout !== 16'h0002) begin n_fail++; $display("FAIL beqz_not_taken: got %h want 0002", pcout); end
    imem[0] = 16'h8ABC;
    apply_reset();
    tick();
    n_chk++; if (pcout !== 16'h0ABC) begin n_fail++; $display("FAIL jmp: got %h want 0abc", pcout); end
  endtask

  task automatic test_stack_bounds();
    clear_mem();
    for (int i = 0; i < 17; i++) imem[i] = 16'hB000 | 16'(i + 1);
    apply_reset();
    repeat (16) tick();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_no_err: got %b want 0", err); end
    tick();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b want 1", err); end
    n_chk++; if (tos !== 16'd16) begin n_fail++; $display("FAIL overflow_tos: got %h want 0010", tos); end
    n_chk++; if (pcout !== 16'd17) begin n_fail++; $display("FAIL overflow_pc: got %h want 0011", pcout); end
    clear_mem();
    imem[0] = 16'hA0FF; imem[1] = 16'hC000; imem[2] = 16'hD000;
    imem[3] = 16'hB005; imem[4] = 16'hE000;
    apply_reset();
    repeat (2) tick();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %b want 1", err); end
    tick();
    n_chk++; if (tos !== 16'h0) begin n_fail++; $display("FAIL underflow_r0: got %h want 0000", tos); end
    // two entries: SADD succeeds, then one entry left so SADD fails
    imem[5] = 16'hE000;
    repeat (2) tick();
    n_chk++; if (tos !== 16'h0005) begin n_fail++; $display("FAIL sadd_sum: got %h want 0005", tos); end
    tick();
    n_chk++; if (tos !== 16'h0005 || pcout !== 16'd6) begin
      n_fail++; $display("FAIL sadd_short: tos %h pc %h want 0005 0006", tos, pcout); end
  endtask

  task automatic test_stall();
    clear_mem();
    imem[0] = 16'hA105; imem[1] = 16'hB007; imem[2] = 16'hD100; imem[3] = 16'h8000;
    apply_reset();
    repeat (2) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (pcout !== 16'd2 || tos !== 16'd7) begin
        n_fail++; $display("FAIL stall_hold: pc %h tos %h want 0002 0007", pcout, tos); end
    end
    stall = 1'b0;
    tick();
    n_chk++; if (pcout !== 16'd3 || tos !== 16'd5) begin
      n_fail++; $display("FAIL stall_resume: pc %h tos %h want 0003 0005", pcout, tos); end
    // reset pulsed between edges must clear immediately
    #2 reset = 1'b1;
    #1;
    n_chk++; if (pcout !== 16'h0 || tos !== 16'h0) begin
      n_fail++; $display("FAIL async_reset: pc %h tos %h want 0000 0000", pcout, tos); end
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [15:0] etos;
    for (int p = 0; p < 6; p++) begin
      clear_mem();
      for (int i = 0; i < 64; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'h0 && $urandom_range(0, 7) != 0) op = 4'h1;
        imem[i] = {op, 12'($urandom())};
        if (op == 4'h8) imem[i][11:0] = 12'($urandom_range(0, 63));
        if (op == 4'h9) imem[i][7:0] = 8'($urandom_range(0, 63));
      end
      apply_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        stall = ($urandom_range(0, 4) == 0);
        tick();
        etos = (ms.size() == 0) ? 16'h0 : ms[$];
        n_chk++; if (pcout !== mpc) begin n_fail++; $display("FAIL rnd_pc p%0d c%0d: got %h want %h", p, cyc, pcout, mpc); end
        n_chk++; if (tos !== etos) begin n_fail++; $display("FAIL rnd_tos p%0d c%0d: got %h want %h", p, cyc, tos, etos); end
        n_chk++; if (halted !== mhalt) begin n_fail++; $display("FAIL rnd_halted p%0d c%0d: got %b want %b", p, cyc, halted, mhalt); end
        n_chk++; if (err !== merr) begin n_fail++; $display("FAIL rnd_err p%0d c%0d: got %b want %b", p, cyc, err, merr); end
      end
      stall = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    clear_mem();
    model_reset();
    test_reset();
    test_stack_program();
    test_alu();
    test_branch();
    test_stack_bounds();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
